// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and line-level constants
// used by both the transmitter and receiver sides.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_LINE_IDLE = 1'b1;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Output side of the UART receiver: byte handshake plus error/status flags.
// Handshake: a byte transfers on every CLK edge where valid=1 and ready=1; while valid=1 and ready=0, data holds.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output data, valid, frame_err, overrun_err, busy,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, overrun_err, busy,
    output ready
  );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// Divide-by-CLKS_PER_BIT bit timer; strobe marks the mid-bit sample point,
// counted from the cycle in which restart is asserted.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic restart,
  output logic strobe
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;
  logic [CW-1:0] cnt_nxt;

  // restart treats the current cycle as count 0, so a start edge sampled
  // at t gets its first strobe at t + MID.
  always_comb begin
    cnt_eff = restart ? '0 : cnt;
    strobe  = (cnt_eff == MID);
    cnt_nxt = (cnt_eff == LAST) ? '0 : cnt_eff + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) cnt <= '0;
    else         cnt <= cnt_nxt;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/8N1 MSB-first deserialiser with a 1-entry output
// holding register, framing and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        rx,
  uart_rx_if.master   rx_if,
  output uart_state_e dbg_state
);

  localparam int             CNT_W    = $clog2(DATA_BITS + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_err_q;
  logic                 start_det;
  logic                 strobe;
  logic                 byte_done;
  logic                 frame_bad;

  assign start_det = (state == IDLE) && (rx == UART_START_BIT);

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK    (CLK),
    .RESETN (RESETN),
    .restart(start_det),
    .strobe (strobe)
  );

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    byte_done   = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (rx == UART_START_BIT) begin
          // At one clock per bit the start sample is this very cycle.
          state_nxt   = (CLKS_PER_BIT == 1) ? DATA : START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (strobe) state_nxt = (rx == UART_START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (strobe) begin
          shift_nxt = {shift[DATA_BITS-2:0], rx};
          if (bit_cnt == LAST_BIT) begin
            state_nxt   = STOP;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (strobe) begin
          if (rx == UART_STOP_BIT) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // A line held low after a bad stop must not look like a new start.
        if (rx == UART_LINE_IDLE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      shift         <= shift_nxt;
      frame_err_q   <= frame_bad;
      overrun_err_q <= byte_done && valid_q && !rx_if.ready;
      if (byte_done && (!valid_q || rx_if.ready)) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.data        = data_q;
  assign rx_if.valid       = valid_q;
  assign rx_if.frame_err   = frame_err_q;
  assign rx_if.overrun_err = overrun_err_q;
  assign rx_if.busy        = (state != IDLE);
  assign dbg_state         = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 and 4 clocks per bit: scoreboard of
// expected bytes plus cycle-accurate event logs for valid and error pulses.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx1;
  logic        rx4;
  uart_state_e st1;
  uart_state_e st4;

  uart_rx_if if1 ();
  uart_rx_if if4 ();

  uart_rx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
    .CLK(clk), .RESETN(resetn), .rx(rx1), .rx_if(if1), .dbg_state(st1)
  );

  uart_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut4 (
    .CLK(clk), .RESETN(resetn), .rx(rx4), .rx_if(if4), .dbg_state(st4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q4[$];
  int v1_cyc[$], fe1_cyc[$], ov1_cyc[$];
  int v4_cyc[$], fe4_cyc[$], ov4_cyc[$];

  function automatic int elem(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (resetn === 1'b1) begin
      if (if1.valid === 1'b1 && if1.ready === 1'b1) begin
        v1_cyc.push_back(cyc);
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL dut1_unexpected_byte: got %h at cycle %0d, want none", if1.data, cyc);
        end else begin
          e = exp_q1.pop_front();
          if (if1.data !== e) begin
            errors++;
            $display("FAIL dut1_data: got %h, want %h (cycle %0d)", if1.data, e, cyc);
          end
        end
      end
      if (if4.valid === 1'b1 && if4.ready === 1'b1) begin
        v4_cyc.push_back(cyc);
        checks++;
        if (exp_q4.size() == 0) begin
          errors++;
          $display("FAIL dut4_unexpected_byte: got %h at cycle %0d, want none", if4.data, cyc);
        end else begin
          e = exp_q4.pop_front();
          if (if4.data !== e) begin
            errors++;
            $display("FAIL dut4_data: got %h, want %h (cycle %0d)", if4.data, e, cyc);
          end
        end
      end
      if (if1.frame_err === 1'b1)   fe1_cyc.push_back(cyc);
      if (if1.overrun_err === 1'b1) ov1_cyc.push_back(cyc);
      if (if4.frame_err === 1'b1)   fe4_cyc.push_back(cyc);
      if (if4.overrun_err === 1'b1) ov4_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick1(input logic v);
    @(posedge clk); #1;
    rx1 = v;
  endtask

  task automatic tick4(input logic v);
    @(posedge clk); #1;
    rx4 = v;
  endtask

  task automatic send1(input logic [7:0] b, input logic stop, output int t);
    tick1(1'b0);
    t = cyc;
    for (int i = 7; i >= 0; i--) tick1(b[i]);
    tick1(stop);
  endtask

  task automatic send4(input logic [7:0] b, output int t);
    tick4(1'b0);
    t = cyc;
    repeat (3) tick4(1'b0);
    for (int i = 7; i >= 0; i--) repeat (4) tick4(b[i]);
    repeat (4) tick4(1'b1);
  endtask

  task automatic clear_logs();
    v1_cyc.delete(); fe1_cyc.delete(); ov1_cyc.delete();
    v4_cyc.delete(); fe4_cyc.delete(); ov4_cyc.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if1.valid, if1.frame_err, if1.overrun_err, if1.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags1: got %b, want 0000",
               {if1.valid, if1.frame_err, if1.overrun_err, if1.busy});
    end
    checks++;
    if (if1.data !== 8'h00) begin
      errors++; $display("FAIL reset_data1: got %h, want 00", if1.data);
    end
    checks++;
    if (st1 !== IDLE) begin
      errors++; $display("FAIL reset_state1: got %0d, want %0d", st1, IDLE);
    end
    checks++;
    if ({if4.valid, if4.frame_err, if4.overrun_err, if4.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags4: got %b, want 0000",
               {if4.valid, if4.frame_err, if4.overrun_err, if4.busy});
    end
    checks++;
    if (if4.data !== 8'h00) begin
      errors++; $display("FAIL reset_data4: got %h, want 00", if4.data);
    end
    checks++;
    if (st4 !== IDLE) begin
      errors++; $display("FAIL reset_state4: got %0d, want %0d", st4, IDLE);
    end
    resetn = 1'b1;
    repeat (2) tick1(1'b1);
  endtask

  task automatic test_single();
    int t;
    clear_logs();
    if1.ready = 1'b1;
    exp_q1.push_back(8'hA5);
    send1(8'hA5, 1'b1, t);
    repeat (3) tick1(1'b1);
    checks++;
    if (v1_cyc.size() != 1 || elem(v1_cyc, 0) != t + 10) begin
      errors++;
      $display("FAIL single_valid: got %0d pulses first at %0d, want 1 at %0d",
               v1_cyc.size(), elem(v1_cyc, 0), t + 10);
    end
    checks++;
    if (fe1_cyc.size() + ov1_cyc.size() != 0) begin
      errors++;
      $display("FAIL single_errs: got fe=%0d ov=%0d, want 0 0", fe1_cyc.size(), ov1_cyc.size());
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    clear_logs();
    exp_q1.push_back(8'h3C);
    exp_q1.push_back(8'hC3);
    send1(8'h3C, 1'b1, t1);
    send1(8'hC3, 1'b1, t2);
    repeat (3) tick1(1'b1);
    checks++;
    if (v1_cyc.size() != 2 || elem(v1_cyc, 0) != t1 + 10 || elem(v1_cyc, 1) != t1 + 20) begin
      errors++;
      $display("FAIL b2b_valid: got n=%0d at %0d,%0d, want 2 at %0d,%0d",
               v1_cyc.size(), elem(v1_cyc, 0), elem(v1_cyc, 1), t1 + 10, t1 + 20);
    end
    checks++;
    if (fe1_cyc.size() + ov1_cyc.size() != 0) begin
      errors++;
      $display("FAIL b2b_errs: got fe=%0d ov=%0d, want 0 0", fe1_cyc.size(), ov1_cyc.size());
    end
  endtask

  task automatic test_frame_err();
    int t;
    clear_logs();
    send1(8'h81, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      tick1(1'b0);
      checks++;
      if (if1.busy !== 1'b1) begin
        errors++; $display("FAIL break_busy: got %b at cycle %0d, want 1", if1.busy, cyc);
      end
    end
    tick1(1'b1);
    tick1(1'b1);
    checks++;
    if (if1.busy !== 1'b0 || st1 !== IDLE) begin
      errors++;
      $display("FAIL break_exit: got busy=%b state=%0d, want busy=0 state=%0d", if1.busy, st1, IDLE);
    end
    repeat (10) tick1(1'b1);
    checks++;
    if (fe1_cyc.size() != 1 || elem(fe1_cyc, 0) != t + 10) begin
      errors++;
      $display("FAIL frame_err_pulse: got n=%0d at %0d, want 1 at %0d",
               fe1_cyc.size(), elem(fe1_cyc, 0), t + 10);
    end
    checks++;
    if (v1_cyc.size() + ov1_cyc.size() != 0) begin
      errors++;
      $display("FAIL frame_err_spurious: got valid=%0d ov=%0d, want 0 0", v1_cyc.size(), ov1_cyc.size());
    end
  endtask

  task automatic test_overrun();
    int t1, t2;
    clear_logs();
    if1.ready = 1'b0;
    send1(8'h11, 1'b1, t1);
    send1(8'h22, 1'b1, t2);
    repeat (3) tick1(1'b1);
    checks++;
    if (if1.valid !== 1'b1 || if1.data !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b data=%h, want 1 11", if1.valid, if1.data);
    end
    checks++;
    if (ov1_cyc.size() != 1 || elem(ov1_cyc, 0) != t1 + 20) begin
      errors++;
      $display("FAIL overrun_pulse: got n=%0d at %0d, want 1 at %0d",
               ov1_cyc.size(), elem(ov1_cyc, 0), t1 + 20);
    end
    checks++;
    if (fe1_cyc.size() != 0) begin
      errors++; $display("FAIL overrun_fe: got %0d frame errors, want 0", fe1_cyc.size());
    end
    exp_q1.push_back(8'h11);
    if1.ready = 1'b1;
    tick1(1'b1);
    checks++;
    if (if1.valid !== 1'b0 || v1_cyc.size() != 1) begin
      errors++;
      $display("FAIL overrun_drain: got valid=%b accepts=%0d, want 0 1", if1.valid, v1_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_logs();
    if1.ready = 1'b0;
    send1(8'h33, 1'b1, t);
    repeat (2) tick1(1'b1);
    tick1(1'b0);
    repeat (4) tick1(1'b1);
    resetn = 1'b0;
    tick1(1'b1);
    checks++;
    if ({if1.valid, if1.frame_err, if1.overrun_err, if1.busy} !== 4'b0000 || if1.data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got flags=%b data=%h, want 0000 00",
               {if1.valid, if1.frame_err, if1.overrun_err, if1.busy}, if1.data);
    end
    resetn = 1'b1;
    if1.ready = 1'b1;
    repeat (2) tick1(1'b1);
    clear_logs();
    exp_q1.push_back(8'h5A);
    send1(8'h5A, 1'b1, t);
    repeat (3) tick1(1'b1);
    checks++;
    if (v1_cyc.size() != 1 || elem(v1_cyc, 0) != t + 10) begin
      errors++;
      $display("FAIL midreset_next: got n=%0d at %0d, want 1 at %0d",
               v1_cyc.size(), elem(v1_cyc, 0), t + 10);
    end
  endtask

  task automatic test_clks4();
    int t;
    clear_logs();
    if4.ready = 1'b1;
    tick4(1'b0);
    tick4(1'b1);
    checks++;
    if (st4 !== START) begin
      errors++; $display("FAIL glitch_start: got state=%0d, want %0d", st4, START);
    end
    repeat (4) tick4(1'b1);
    checks++;
    if (st4 !== IDLE || if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: got state=%0d busy=%b, want %0d 0", st4, if4.busy, IDLE);
    end
    exp_q4.push_back(8'h96);
    send4(8'h96, t);
    repeat (4) tick4(1'b1);
    checks++;
    if (v4_cyc.size() != 1 || elem(v4_cyc, 0) != t + 38) begin
      errors++;
      $display("FAIL clks4_valid: got n=%0d at %0d, want 1 at %0d",
               v4_cyc.size(), elem(v4_cyc, 0), t + 38);
    end
    checks++;
    if (fe4_cyc.size() + ov4_cyc.size() != 0) begin
      errors++;
      $display("FAIL clks4_errs: got fe=%0d ov=%0d, want 0 0", fe4_cyc.size(), ov4_cyc.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rx1       = 1'b1;
    rx4       = 1'b1;
    resetn    = 1'b0;
    if1.ready = 1'b1;
    if4.ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_clks4();
    checks++;
    if (exp_q1.size() + exp_q4.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d,%0d bytes never received, want 0,0",
               exp_q1.size(), exp_q4.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that consumes the 1-bit line produced by the single-cycle-per-bit UART transmitter in the same clock domain.
- Frame format: start bit 0, 8 data bits MSB-first, stop bit 1; line idles high.
- Reassembles each byte and presents it on a valid/ready output with a 1-entry holding register.
- Flags framing and overrun errors.
- Sits directly downstream of the transmitter, or downstream of a pad loopback in test.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit; must be ≥1. A value of 1 matches the transmitter's one-bit-per-clock output.
- DATA_BITS, 8, payload bits per frame, received MSB-first.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  synchronous, active-low reset.
- rx  in  1  serial line, same clock domain as the transmitter; no synchronizer. Idle level is 1.
- data  out  DATA_BITS  received byte; valid only while valid=1.
- valid  out  1  holding register full.
- ready  in  1  consumer accepts data when valid&ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_err  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset (RESETN=0 at a CLK edge):
- state=IDLE; data=0x00; valid=0; frame_err=0; overrun_err=0; busy=0; bit timer and bit counter cleared.
- Reset mid-frame discards the partial byte.

Bit sampling:
- Let t be the first cycle in IDLE with rx=0.
- Bit k (k=0 start, 1..DATA_BITS data, DATA_BITS+1 stop) is sampled at cycle t + k*CLKS_PER_BIT + (CLKS_PER_BIT-1)/2, using integer division.
- For CLKS_PER_BIT=1: start at t, data at t+1..t+8, stop at t+9.

FSM states:
- IDLE: rx=0 → START (or directly to DATA when CLKS_PER_BIT=1, since the start sample is at t).
- START: at the mid-bit sample, rx=1 → IDLE (glitch, no error); rx=0 → DATA.
- DATA: shift register ← {shift[DATA_BITS-2:0], rx} at each sample. After DATA_BITS samples → STOP.
- STOP, stop sample = 1: byte complete, go to IDLE. The next cycle may already be a new start bit; back-to-back frames with a 1-cycle stop must be received with no gap.
- STOP, stop sample = 0: frame_err pulses for 1 cycle, byte discarded, go to BREAK.
- BREAK: wait for rx=1, then go to IDLE. This prevents a held-low line from being read as a start bit.

Output register:
- On byte completion with valid=0: data ← shift, valid ← 1 on the next cycle. Latency from stop sample to valid is 1 cycle.
- valid&ready: valid ← 0 unless a byte completes in the same cycle.
- Byte completes while valid&ready: new byte loaded, valid stays 1, no overrun.
- Byte completes while valid & !ready: new byte dropped, old data held, overrun_err pulses 1 cycle.
- data is stable while valid=1 & ready=0.
- frame_err and overrun_err are mutually exclusive; each is registered.
- busy=1 in START, DATA, STOP and BREAK.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps; bit counter width is clog2(DATA_BITS+2).

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - UART_DATA_BITS=8
  - UART_LINE_IDLE=1'b1, UART_START_BIT=1'b0, UART_STOP_BIT=1'b1
- The transmitter-side constants are shared from the same package.
- One sub-module: uart_rx_bit_timer.
  - Divide-by-CLKS_PER_BIT counter with a mid-bit sample strobe.
  - Restarted on start detect; strobes every cycle when CLKS_PER_BIT=1.

Test Plan:
1. CLKS_PER_BIT=1, ready=1; rx = 0,1,0,1,0,0,1,0,1,1 starting at cycle t → valid=1, data=0xA5 at cycle t+10, for 1 cycle; no errors.
2. Back-to-back frames 0x3C then 0xC3 with a single stop cycle between them (second start at t+10) → two valid pulses at t+10 and t+20 with data 0x3C, 0xC3.
3. Frame 0x81 with stop sampled 0, rx held low 5 more cycles, then high → frame_err pulse at t+10, no valid, busy stays 1 until rx returns high, no spurious start.
4. ready=0; frames 0x11 then 0x22 → data=0x11 held, valid=1, overrun_err pulse when 0x22 completes; after ready=1, 0x11 is accepted and valid=0.
5. RESETN=0 at data bit 4 of frame 0xFF, released with rx=1 → all outputs zero, busy=0; the next clean frame 0x5A is received correctly.
6. CLKS_PER_BIT=4; rx low for 1 cycle only (glitch) → returns to IDLE, no valid, no error. A full 0x96 frame at 4 cycles/bit is received with valid at t+4*9+1+1 = t+38.
